// File: rtl/uart_16550_pkg.sv
// rtl/uart_16550_pkg.sv - shared types and constants for the UART 16550 Rx FIFO controller
package uart_16550_pkg;

    typedef enum logic [1:0] {
        POP_IDLE   = 2'd0,
        POP_POP    = 2'd1,
        POP_SETTLE = 2'd2
    } pop_state_t;

    localparam logic [8:0] TRIG_LVL_1  = 9'd1;
    localparam logic [8:0] TRIG_LVL_4  = 9'd4;
    localparam logic [8:0] TRIG_LVL_8  = 9'd8;
    localparam logic [8:0] TRIG_LVL_14 = 9'd14;

    localparam logic [3:0] CHAR_BITS_MIN = 4'd7;
    localparam logic [3:0] CHAR_BITS_MAX = 4'd12;

    localparam int TIMEOUT_CNT_W = 10;
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_MULT = 10'd64;

    function automatic logic [8:0] trigger_level(input logic [1:0] sel);
        logic [8:0] lvl;
        case (sel)
            2'b00:   lvl = TRIG_LVL_1;
            2'b01:   lvl = TRIG_LVL_4;
            2'b10:   lvl = TRIG_LVL_8;
            default: lvl = TRIG_LVL_14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_16550_rx_timeout.sv
// rtl/uart_16550_rx_timeout.sv - character-timeout counter and IRQ flop
module uart_16550_rx_timeout
    import uart_16550_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_rbr_read,
    input  logic       i_empty,
    input  logic       i_tick,
    input  logic [3:0] i_char_bits,
    output logic       o_irq
);

    logic [3:0]               w_char_bits;
    logic [TIMEOUT_CNT_W-1:0] w_limit;
    logic [TIMEOUT_CNT_W-1:0] r_cnt;
    logic                     r_irq;

    assign w_char_bits = (i_char_bits < CHAR_BITS_MIN) ? CHAR_BITS_MIN :
                         (i_char_bits > CHAR_BITS_MAX) ? CHAR_BITS_MAX : i_char_bits;
    assign w_limit     = TIMEOUT_CNT_W'(w_char_bits) * TIMEOUT_MULT;

    // Any FIFO activity (or an empty FIFO) means the line is not idle, so the count restarts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
        end else begin
            if (i_push || i_pop || i_rbr_read || i_empty)
                r_cnt <= '0;
            else if (i_tick && (r_cnt < w_limit))
                r_cnt <= r_cnt + TIMEOUT_CNT_W'(1);

            if (i_push || i_pop)
                r_irq <= 1'b0;
            else if (r_cnt == w_limit)
                r_irq <= 1'b1;
        end
    end

    assign o_irq = r_irq;

endmodule

// File: rtl/uart_16550_rx_fifo_ctrl.sv
// rtl/uart_16550_rx_fifo_ctrl.sv - Rx FIFO pop sequencing, LSR status and Rx interrupts
// Optional overrun detection: define UART_16550_RX_OVERRUN_EN.
module uart_16550_rx_fifo_ctrl
    import uart_16550_pkg::*;
(
    input  logic       WBs_CLK_i,
    input  logic       WBs_RST_i,
    input  logic       Rx_FIFO_Enable_i,
    input  logic       Rx_FIFO_Flush_i,
    input  logic [1:0] Rx_Trigger_Level_i,
    input  logic       Rx_FIFO_Push_i,
    input  logic [8:0] Rx_FIFO_Level_i,
    input  logic       Rx_FIFO_Empty_i,
    input  logic       Rx_FIFO_Full_i,
    input  logic       RBR_Read_i,
    input  logic       LSR_Read_i,
    input  logic       Baud16_Tick_i,
    input  logic [3:0] Char_Bits_i,
    output logic       Rx_FIFO_Pop_o,
    output logic       Rx_Data_Ready_o,
    output logic       Rx_Overrun_o,
    output logic       Rx_Data_Avail_IRQ_o,
    output logic       Rx_Timeout_IRQ_o
);

    pop_state_t r_state;
    logic       r_pop;
    logic       r_data_ready;
    logic       r_data_avail;
    logic       w_flush;
    logic       w_data_ready_nxt;

    assign w_flush = Rx_FIFO_Flush_i | ~Rx_FIFO_Enable_i;

    // SETTLE gives the FIFO one cycle to update its flags before another read is honoured.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            r_state <= POP_IDLE;
            r_pop   <= 1'b0;
        end else if (w_flush) begin
            r_state <= POP_IDLE;
            r_pop   <= 1'b0;
        end else begin
            r_pop <= 1'b0;
            case (r_state)
                POP_IDLE: begin
                    if (RBR_Read_i && !Rx_FIFO_Empty_i) begin
                        r_state <= POP_POP;
                        r_pop   <= 1'b1;
                    end
                end
                POP_POP:    r_state <= POP_SETTLE;
                POP_SETTLE: r_state <= POP_IDLE;
                default:    r_state <= POP_IDLE;
            endcase
        end
    end

    always_comb begin
        w_data_ready_nxt = r_data_ready;
        if (Rx_FIFO_Enable_i)
            w_data_ready_nxt = ~Rx_FIFO_Empty_i;
        else if (Rx_FIFO_Push_i)
            w_data_ready_nxt = 1'b1;
        else if (RBR_Read_i)
            w_data_ready_nxt = 1'b0;
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            r_data_ready <= 1'b0;
            r_data_avail <= 1'b0;
        end else begin
            r_data_ready <= w_data_ready_nxt;
            r_data_avail <= Rx_FIFO_Enable_i ?
                            (Rx_FIFO_Level_i >= trigger_level(Rx_Trigger_Level_i)) :
                            w_data_ready_nxt;
        end
    end

`ifdef UART_16550_RX_OVERRUN_EN
    logic r_overrun;
    logic w_overrun_set;

    assign w_overrun_set = Rx_FIFO_Push_i & (Rx_FIFO_Enable_i ? Rx_FIFO_Full_i : r_data_ready);

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            r_overrun <= 1'b0;
        else if (w_overrun_set)
            r_overrun <= 1'b1;
        else if (LSR_Read_i)
            r_overrun <= 1'b0;
    end

    assign Rx_Overrun_o = r_overrun;
`else
    logic w_unused_ovr;
    assign w_unused_ovr = LSR_Read_i | Rx_FIFO_Full_i;
    assign Rx_Overrun_o = 1'b0;
`endif

    uart_16550_rx_timeout u_timeout (
        .i_clk       (WBs_CLK_i),
        .i_rst       (WBs_RST_i),
        .i_clear     (w_flush),
        .i_push      (Rx_FIFO_Push_i),
        .i_pop       (r_pop),
        .i_rbr_read  (RBR_Read_i),
        .i_empty     (Rx_FIFO_Empty_i),
        .i_tick      (Baud16_Tick_i),
        .i_char_bits (Char_Bits_i),
        .o_irq       (Rx_Timeout_IRQ_o)
    );

    assign Rx_FIFO_Pop_o       = r_pop;
    assign Rx_Data_Ready_o     = r_data_ready;
    assign Rx_Data_Avail_IRQ_o = r_data_avail;

endmodule

// File: tb/tb_uart_16550_rx_fifo_ctrl.sv
// tb/tb_uart_16550_rx_fifo_ctrl.sv - scoreboard bench for uart_16550_rx_fifo_ctrl
module tb_uart_16550_rx_fifo_ctrl;

    localparam int DEPTH = 16;
`ifdef UART_16550_RX_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, flush = 1'b0, push = 1'b0, rbr = 1'b0, lsr = 1'b0, tick = 1'b0;
    logic [1:0] trig = 2'd0;
    logic [3:0] cb = 4'd10;
    logic [8:0] level;
    logic       empty, full;
    logic       pop_o, dr_o, ovr_o, da_o, to_o;

    always #5 clk = ~clk;

    uart_16550_rx_fifo_ctrl dut (
        .WBs_CLK_i           (clk),
        .WBs_RST_i           (rst),
        .Rx_FIFO_Enable_i    (en),
        .Rx_FIFO_Flush_i     (flush),
        .Rx_Trigger_Level_i  (trig),
        .Rx_FIFO_Push_i      (push),
        .Rx_FIFO_Level_i     (level),
        .Rx_FIFO_Empty_i     (empty),
        .Rx_FIFO_Full_i      (full),
        .RBR_Read_i          (rbr),
        .LSR_Read_i          (lsr),
        .Baud16_Tick_i       (tick),
        .Char_Bits_i         (cb),
        .Rx_FIFO_Pop_o       (pop_o),
        .Rx_Data_Ready_o     (dr_o),
        .Rx_Overrun_o        (ovr_o),
        .Rx_Data_Avail_IRQ_o (da_o),
        .Rx_Timeout_IRQ_o    (to_o)
    );

    typedef struct packed {
        logic pop;
        logic dr;
        logic ovr;
        logic da;
        logic to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, dut_pops = 0;
    // reference model: FIFO occupancy, pending pop cycle, idle-tick count and status bits
    int   fifo_cnt = 0, fifo_nxt = 0, pop_at = -1, ready_at = 0, quiet = 0;
    logic m_dr = 1'b0, m_ovr = 1'b0, m_to = 1'b0;

    assign level = 9'(fifo_cnt);
    assign empty = (fifo_cnt == 0);
    assign full  = (fifo_cnt >= DEPTH);

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0b expected=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pop_o === 1'b1) dut_pops++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pop", pop_o, e.pop);
            check("data_ready", dr_o, e.dr);
            check("overrun", ovr_o, e.ovr);
            check("data_avail_irq", da_o, e.da);
            check("timeout_irq", to_o, e.to);
        end
    end

    function automatic int trig_val(input logic [1:0] sel);
        int tv[4] = '{1, 4, 8, 14};
        return tv[sel];
    endfunction

    // Predicts the outputs after the coming clock edge from the inputs of this cycle.
    task automatic model_eval();
        exp_t e;
        int   lim, c;
        logic dis, pop_now, is_full, dr_n, to_n;
        c       = cyc;
        dis     = flush || !en;
        pop_now = (pop_at == c);
        is_full = (fifo_cnt >= DEPTH);
        lim     = 64 * ((cb < 4'd7) ? 7 : (cb > 4'd12) ? 12 : int'(cb));

        if (dis) fifo_nxt = 0;
        else fifo_nxt = fifo_cnt + ((push && !is_full) ? 1 : 0) - (pop_now ? 1 : 0);

        if (OVR_EN) begin
            if (push && (en ? is_full : m_dr)) m_ovr = 1'b1;
            else if (lsr) m_ovr = 1'b0;
        end

        if (dis) begin
            pop_at   = -1;
            ready_at = c + 1;
        end else if (rbr && fifo_cnt != 0 && c >= ready_at) begin
            pop_at   = c + 1;
            ready_at = c + 3;
        end

        if (en) dr_n = (fifo_cnt != 0);
        else if (push) dr_n = 1'b1;
        else if (rbr) dr_n = 1'b0;
        else dr_n = m_dr;

        if (dis) begin
            quiet = 0;
            m_to  = 1'b0;
        end else begin
            to_n = (push || pop_now) ? 1'b0 : (m_to || quiet == lim);
            if (push || pop_now || rbr || fifo_cnt == 0) quiet = 0;
            else if (tick && quiet < lim) quiet++;
            m_to = to_n;
        end

        e.pop = (pop_at == c + 1);
        e.dr  = dr_n;
        e.ovr = m_ovr;
        e.da  = en ? (fifo_cnt >= trig_val(trig)) : dr_n;
        e.to  = m_to;
        m_dr  = dr_n;
        sb_q.push_back(e);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        fifo_cnt = fifo_nxt;
        push = 1'b0; rbr = 1'b0; lsr = 1'b0; flush = 1'b0; tick = 1'b0;
    endtask

    task automatic model_reset();
        fifo_cnt = 0; pop_at = -1; ready_at = cyc; quiet = 0;
        m_dr = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check("async_rst_pop", pop_o, 1'b0);
        check("async_rst_dr", dr_o, 1'b0);
        check("async_rst_ovr", ovr_o, 1'b0);
        check("async_rst_da", da_o, 1'b0);
        check("async_rst_to", to_o, 1'b0);
        sb_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        rst = 1'b0;
        sb_q.push_back('0);
    endtask

    task automatic measure_timeout(input string name, input int exp_ticks);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (to_o === 1'b1) seen = 1'b1;
            else begin
                tick = (i % 2 == 1);
                if (tick) n++;
                step();
            end
        end
        if (!seen) n = -1;
        check_int(name, n, exp_ticks);
    endtask

    task automatic do_push(input int n);
        for (int i = 0; i < n; i++) begin
            push = 1'b1;
            step();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base, pr, rr, tr;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        sb_q.push_back('0);
        en = 1'b1; cb = 4'd10; trig = 2'd0;
        idle(2);

        // pop sequencing: reads at 0, 1, 3 give pops at 1 and 4
        do_push(3);
        idle(2);
        base = dut_pops;
        rbr = 1'b1; step();
        rbr = 1'b1; step();
        step();
        rbr = 1'b1; step();
        idle(4);
        check_int("pop_count_seq", dut_pops - base, 2);

        // trigger level 8
        flush = 1'b1; step();
        trig = 2'd2;
        do_push(7);
        idle(2);
        check("trig_below", da_o, 1'b0);
        do_push(1);
        check("trig_lag", da_o, 1'b0);
        step();
        check("trig_reached", da_o, 1'b1);
        rbr = 1'b1; step();
        idle(2);
        check("trig_after_pop", da_o, 1'b0);

        // character timeout, restart by push, clear by pop, clamping
        flush = 1'b1; step();
        cb = 4'd10; trig = 2'd0;
        do_push(1);
        measure_timeout("timeout_cb10", 640);
        rbr = 1'b1; step();
        idle(2);
        check("timeout_pop_clear", to_o, 1'b0);
        do_push(1);
        for (int i = 0; i < 1278; i++) begin
            tick = (i % 2 == 1);
            step();
        end
        check("timeout_at_639", to_o, 1'b0);
        do_push(1);
        measure_timeout("timeout_restart", 640);
        flush = 1'b1; cb = 4'd3; step();
        do_push(1);
        measure_timeout("timeout_clamp_lo", 448);
        flush = 1'b1; cb = 4'd15; step();
        do_push(1);
        measure_timeout("timeout_clamp_hi", 768);

        // overrun on push into a full FIFO
        flush = 1'b1; cb = 4'd7; step();
        do_push(DEPTH);
        do_push(1);
        step();
        check("overrun_set", ovr_o, OVR_EN);
        rbr = 1'b1; step();
        idle(3);
        check("overrun_held", ovr_o, OVR_EN);
        lsr = 1'b1; step();
        check("overrun_lsr_clear", ovr_o, 1'b0);

        // flush during POP with timeout pending
        flush = 1'b1; step();
        do_push(1);
        measure_timeout("timeout_cb7", 448);
        rbr = 1'b1; step();
        check("pop_before_flush", pop_o, 1'b1);
        flush = 1'b1; step();
        check("flush_pop", pop_o, 1'b0);
        check("flush_to", to_o, 1'b0);

        // reset during POP and mid-count
        do_push(2);
        rbr = 1'b1; step();
        check("pop_before_rst", pop_o, 1'b1);
        reset_pulse();
        do_push(1);
        for (int i = 0; i < 300; i++) begin
            tick = (i % 2 == 1);
            step();
        end
        check("dr_before_rst", dr_o, 1'b1);
        reset_pulse();

        // 16450 holding-register mode
        en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            push = ($urandom_range(0, 3) == 0);
            rbr  = ($urandom_range(0, 3) == 0);
            lsr  = ($urandom_range(0, 7) == 0);
            tick = $urandom_range(0, 1);
            step();
        end

        // randomized FIFO-mode segments with varying activity rates
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            pr = $urandom_range(2, 12);
            rr = $urandom_range(2, 12);
            tr = $urandom_range(1, 2);
            for (int i = 0; i < 800; i++) begin
                push = ($urandom_range(0, pr - 1) == 0);
                rbr  = ($urandom_range(0, rr - 1) == 0);
                lsr  = ($urandom_range(0, 15) == 0);
                tick = ($urandom_range(0, tr - 1) == 0);
                trig = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 199) == 0) en = ~en;
                if ($urandom_range(0, 63) == 0) flush = 1'b1;
                if (flush || !en) cb = 4'($urandom_range(0, 15));
                step();
            end
        end
        en = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_16550_rx_fifo_ctrl.md
# uart_16550_rx_fifo_ctrl

Receive-side controller for the UART 16550 Rx FIFO datapath. It turns completed CPU reads of RBR into single-cycle FIFO pops, and it generates the 16550 received-data-available interrupt (FCR trigger level) and the character-timeout interrupt. It also generates the LSR Data Ready and Overrun Error status. It sits between the UART register file and the Tx/Rx FIFO block, and runs on the Wishbone fabric clock.

## Interface
- No parameters. Timeout length is derived from port `Char_Bits_i`.
- `WBs_CLK_i` input 1: Wishbone fabric clock.
- `WBs_RST_i` input 1: reset, asynchronous, active-high.
- `Rx_FIFO_Enable_i` input 1: FCR[0]. 1 selects FIFO mode; 0 selects 16450 holding-register mode.
- `Rx_FIFO_Flush_i` input 1: FCR[1] Rx flush strobe.
- `Rx_Trigger_Level_i` input 2: FCR[7:6] trigger select.
- `Rx_FIFO_Push_i` input 1: receiver push strobe, shared with the FIFO.
- `Rx_FIFO_Level_i` input 9: FIFO occupancy.
- `Rx_FIFO_Empty_i` input 1: FIFO empty flag.
- `Rx_FIFO_Full_i` input 1: FIFO full flag.
- `RBR_Read_i` input 1: one-cycle strobe marking a completed Wishbone read of RBR.
- `LSR_Read_i` input 1: one-cycle strobe marking a completed read of LSR.
- `Baud16_Tick_i` input 1: 16x baud clock enable.
- `Char_Bits_i` input 4: bits per frame (start + data + parity + stop), valid range 7..12.
- `Rx_FIFO_Pop_o` output 1: one-cycle pop to the FIFO.
- `Rx_Data_Ready_o` output 1: LSR[0].
- `Rx_Overrun_o` output 1: LSR[1].
- `Rx_Data_Avail_IRQ_o` output 1: IIR priority-2 source.
- `Rx_Timeout_IRQ_o` output 1: IIR character-timeout source.

## Operation
- **Reset:** all outputs are 0, the pop FSM is in IDLE, and the timeout counter is 0.
- **Pop FSM states:** IDLE, POP, SETTLE.
  - IDLE → POP on `RBR_Read_i` when FIFO mode is on and `Rx_FIFO_Empty_i` is 0.
  - POP drives `Rx_FIFO_Pop_o`=1 for exactly one cycle, then moves to SETTLE.
  - SETTLE → IDLE unconditionally, giving one cycle for the FIFO level and flags to update.
  - `RBR_Read_i` is dropped when it arrives in POP or SETTLE.
  - `RBR_Read_i` is also dropped in IDLE when the FIFO is empty.
- **Flush:** `Rx_FIFO_Flush_i` or FIFO-mode disable in any state:
  - next state is IDLE and the next `Rx_FIFO_Pop_o` is 0;
  - the timeout counter and `Rx_Timeout_IRQ_o` clear.
- **Trigger levels:** 00→1, 01→4, 10→8, 11→14.
- **`Rx_Data_Avail_IRQ_o`:**
  - FIFO mode: `Rx_FIFO_Level_i` ≥ trigger level.
  - Non-FIFO mode: equals `Rx_Data_Ready_o`.
- **`Rx_Data_Ready_o`:**
  - FIFO mode: ~`Rx_FIFO_Empty_i`.
  - Non-FIFO mode: set by push, cleared by `RBR_Read_i`; push wins if both occur in the same cycle.
- **Timeout limit:** `Char_Bits_i`×64 ticks, i.e. 4 character times at 16 ticks per bit. `Char_Bits_i` below 7 is clamped to 7 and above 12 to 12. The counter is 10 bits (maximum 768).
- **Timeout counter** (FIFO mode only):
  - clears on push, on pop, on `RBR_Read_i`, or while the FIFO is empty;
  - otherwise increments on `Baud16_Tick_i`;
  - saturates at the limit.
- **`Rx_Timeout_IRQ_o`:** set when the count equals the limit. Cleared by pop, push, flush, or FIFO-mode disable.
- **Overrun:**
  - FIFO mode: push while `Rx_FIFO_Full_i`=1.
  - Non-FIFO mode: push while `Rx_Data_Ready_o`=1.
  - Sets `Rx_Overrun_o`, which stays set until `LSR_Read_i`. If set and clear occur in the same cycle, the set wins.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- **Pop:** `RBR_Read_i` at cycle N gives `Rx_FIFO_Pop_o` at N+1 and the FSM back in IDLE at N+3. The earliest accepted back-to-back read is therefore at N+3.
- **Status/interrupt lag:** `Rx_Data_Ready_o` and `Rx_Data_Avail_IRQ_o` follow FIFO flag/level changes with 1 cycle of lag.
- **Timeout:** the tick that brings the count to the limit sets `Rx_Timeout_IRQ_o` on the next clock edge.
- **Reset mid-operation:** reset asserted during POP forces `Rx_FIFO_Pop_o` to 0 asynchronously.

## Configuration
- Macro: `UART_16550_RX_OVERRUN_EN`.
  - **Defined:** overrun detection operates as described under Operation.
  - **Undefined:** the overrun logic is removed, `Rx_Overrun_o` is tied to 0, and `LSR_Read_i` is unused. The port list is unchanged.

## Structure
- **Shared package `uart_16550_pkg`:**
  - pop FSM state encoding (IDLE/POP/SETTLE);
  - trigger-level constants 1/4/8/14;
  - `CHAR_BITS_MIN`=7 and `CHAR_BITS_MAX`=12;
  - timeout multiplier 64;
  - 10-bit timeout counter width.
- **Sub-module `uart_16550_rx_timeout`:** contains the clamp, the limit multiply, the counter and the IRQ flop. Everything else stays flat in the top module.

## Test plan
- **Pop sequencing:** FIFO mode, 3 pushes, `RBR_Read_i` pulses at cycles 0, 1 and 3 → exactly 2 pops, at cycles 1 and 4. The read at cycle 1 is dropped. `Rx_FIFO_Pop_o` is never high for 2 consecutive cycles.
- **Trigger level:** trigger 10 (8), push 7 bytes → IRQ low. 8th push → IRQ high 1 cycle after level reaches 8. One pop → IRQ low.
- **Character timeout:** `Char_Bits_i`=10, 1 byte in FIFO, continuous ticks → `Rx_Timeout_IRQ_o` rises after exactly 640 ticks. A push at tick 639 restarts the count. A pop clears the IRQ.
- **Clamp:** `Char_Bits_i`=3 → timeout after 448 ticks. `Char_Bits_i`=15 → timeout after 768 ticks.
- **Overrun:** with `UART_16550_RX_OVERRUN_EN` defined, push with `Rx_FIFO_Full_i`=1 → `Rx_Overrun_o`=1. It stays set through pops and clears only on `LSR_Read_i`. With the macro undefined, the output stays 0.
- **Flush and reset mid-operation:** `Rx_FIFO_Flush_i` during POP → FSM in IDLE next cycle and timeout IRQ cleared. `WBs_RST_i` pulse mid-timeout-count → all outputs 0 immediately.
